uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, meaning clk cycles per serial bit (50 MHz / 9600 baud); legal values >= 2.
REQ-002 SHALL have parameter PARITY_EN, default 1, meaning 1 = parity bit inserted after data, 0 = no parity bit.
REQ-003 SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
REQ-004 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-005 SHALL have port nrst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port tx_start  input  1  request to send tx_data; sampled only in IDLE.
REQ-007 SHALL have port tx_data  input  8  byte to transmit; captured in the cycle tx_start is accepted.
REQ-008 SHALL have port tx  output  1  serial line, registered, idle high.
REQ-009 SHALL have port tx_busy  output  1  high from the accept edge until the end of the stop bit.
REQ-010 SHALL have port tx_done  output  1  one-cycle pulse marking frame completion.

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP; any other encoding SHALL return to IDLE on the next edge.
REQ-012 SHALL, in IDLE with tx_start = 1, on the next edge latch tx_data into an 8-bit shift register, enter START, drive tx = 0, set tx_busy = 1, and clear the bit-time counter.
REQ-013 SHALL hold each bit on tx for exactly CLKS_PER_BIT cycles, timed by a counter of width $clog2(CLKS_PER_BIT) that counts 0..CLKS_PER_BIT-1 and then wraps to 0.
REQ-014 SHALL, on the wrap at the end of START, enter DATA and drive tx_data[0].
REQ-015 SHALL send data LSB first; each bit-time wrap in DATA SHALL shift to the next bit, and a 3-bit index SHALL count the bits sent.
REQ-016 SHALL, on the wrap at the end of data bit 7, enter PARITY if PARITY_EN = 1, else enter STOP.
REQ-017 SHALL drive the parity bit as XOR of the latched byte when PARITY_ODD = 0, and as its inverse when PARITY_ODD = 1.
REQ-018 SHALL, on the wrap at the end of PARITY, enter STOP and drive tx = 1.
REQ-019 SHALL, on the wrap at the end of STOP, enter IDLE, keep tx = 1, clear tx_busy, and assert tx_done for exactly one cycle.
REQ-020 SHALL make frame length, from accept edge to the tx_done edge, exactly 11*CLKS_PER_BIT cycles with parity, or 10*CLKS_PER_BIT without.
REQ-021 SHALL ignore tx_start while tx_busy = 1; changes to tx_data after the accept edge SHALL NOT affect the frame in progress.
REQ-022 SHALL accept tx_start in the IDLE cycle in which tx_done = 1, giving back-to-back frames with exactly one extra idle-high cycle between the stop bit and the next start bit.
REQ-023 SHALL never drive tx from combinational logic, so tx is glitch-free.

Reset
REQ-024 SHALL, while nrst = 1, immediately force state = IDLE, tx = 1, tx_busy = 0, tx_done = 0, and clear the counter, bit index and shift register, independent of clk.
REQ-025 SHALL, when nrst is asserted mid-frame, abort the frame with no tx_done pulse; after release the block SHALL idle until a new tx_start.

Verification (CLKS_PER_BIT = 4)
REQ-026 SHALL verify: tx_data = 0xA5, PARITY_EN = 1, PARITY_ODD = 0 -> tx sequence 0,1,0,1,0,0,1,0,1,0,1, each 4 cycles; tx_done pulses 44 cycles after the accept edge.
REQ-027 SHALL verify: tx_data = 0x00, PARITY_ODD = 1 -> parity bit = 1; tx_data = 0xFF, PARITY_ODD = 0 -> parity bit = 0.
REQ-028 SHALL verify: PARITY_EN = 0, tx_data = 0x3C -> 10-bit frame 0,0,0,1,1,1,1,0,0,1; tx_done pulses at cycle 40.
REQ-029 SHALL verify: tx_start held high continuously with tx_data = 0x55 -> second frame's start bit begins exactly 1 cycle after the tx_done cycle; a pulse mid-frame creates no extra frame.
REQ-030 SHALL verify: nrst pulsed during data bit 3 -> tx = 1 and tx_busy = 0 within the same cycle, no tx_done pulse; a new tx_start with 0x81 then produces a correct full frame.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter. It sends one start bit, eight data bits
// (LSB first), an optional parity bit and one stop bit. Every bit is held
// for CLKS_PER_BIT clock cycles.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per serial bit (>= 2)
//   PARITY_EN    : 1 = insert a parity bit after the data bits
//   PARITY_ODD   : 0 = even parity, 1 = odd parity
//
// Ports
//   clk      : system clock (rising edge)
//   nrst     : asynchronous reset, active-high
//   tx_start : send request; sampled only while idle
//   tx_data  : byte to send; captured on the accept edge
//   tx       : registered serial output, idles high
//   tx_busy  : high from the accept edge until the end of the stop bit
//   tx_done  : one-cycle pulse when a frame completes
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter bit          PARITY_EN    = 1'b1,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned           CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       idx_q,   idx_d;
  logic [7:0]       sh_q,    sh_d;
  logic             par_q,   par_d;
  logic             tx_q,    tx_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             wrap;

  assign wrap = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // Bit-time counter only runs while a frame is in flight.
    if (state_q != S_IDLE) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          sh_d    = tx_data;
          // Parity is taken from the byte at accept time because the
          // shift register is consumed as the data bits go out.
          par_d   = (^tx_data) ^ PARITY_ODD;
          idx_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (wrap) begin
          tx_d    = sh_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (wrap) begin
          if (idx_q == 3'd7) begin
            if (PARITY_EN) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            // sh_q[0] is the bit on the line now; sh_q[1] goes out next.
            tx_d  = sh_q[1];
            sh_d  = {1'b0, sh_q[7:1]};
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (wrap) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (wrap) begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
